reg_op_sequencer: RTL and testbench

//  Operand sequencer that sits directly upstream of reg_file. It accepts one

---
 rtl/reg_op_sequencer.sv | 150 +++++++++++++++
 tb/tb_reg_op_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// Operand sequencer in front of reg_file: accepts one register-to-register
// instruction, reads both sources, computes the ALU result and writes it back.
module reg_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    output logic [ADDR_W-1:0] rf_r1_addr,
    output logic [ADDR_W-1:0] rf_r2_addr,
    input  logic [DATA_W-1:0] rf_r1_data,
    input  logic [DATA_W-1:0] rf_r2_data,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_ctrl,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_carry
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
    localparam logic [2:0] OP_SHR1 = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [2:0]          r_opcode;
    logic [ADDR_W-1:0]   r_rd;
    logic [ADDR_W-1:0]   r_r1Addr;
    logic [ADDR_W-1:0]   r_r2Addr;
    logic [DATA_W-1:0]   r_opA;
    logic [DATA_W-1:0]   r_opB;
    logic [DATA_W:0]     r_alu;
    logic [DATA_W:0]     w_aluNext;
    logic [ADDR_W-1:0]   r_writeAddr;
    logic [DATA_W-1:0]   r_result;
    logic                r_flagZero;
    logic                r_flagCarry;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = READ;
            READ:    w_nextState = EXEC;
            EXEC:    w_nextState = WB;
            WB:      w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A reset arriving during WB must not let that cycle's write reach reg_file.
    always_comb begin
        in_ready      = (r_state == IDLE);
        rf_write_ctrl = (r_state == WB) && !reset;
        done          = (r_state == WB) && !reset;
    end

    // Top bit of the 9-bit result is carry, borrow or the shifted-out bit.
    always_comb begin
        w_aluNext = '0;
        case (r_opcode)
            OP_ADD:  w_aluNext = {1'b0, r_opA} + {1'b0, r_opB};
            OP_SUB:  w_aluNext = {1'b0, r_opA} - {1'b0, r_opB};
            OP_AND:  w_aluNext = {1'b0, r_opA & r_opB};
            OP_OR:   w_aluNext = {1'b0, r_opA | r_opB};
            OP_XOR:  w_aluNext = {1'b0, r_opA ^ r_opB};
            OP_SHL1: w_aluNext = {r_opA, 1'b0};
            OP_SHR1: w_aluNext = {r_opA[0], 1'b0, r_opA[DATA_W-1:1]};
            OP_MOV:  w_aluNext = {1'b0, r_opA};
            default: w_aluNext = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_opcode    <= '0;
            r_rd        <= '0;
            r_r1Addr    <= '0;
            r_r2Addr    <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_alu       <= '0;
            r_writeAddr <= '0;
            r_result    <= '0;
            r_flagZero  <= 1'b0;
            r_flagCarry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opcode <= in_opcode;
                        r_rd     <= in_rd;
                        r_r1Addr <= in_rs1;
                        r_r2Addr <= in_rs2;
                    end
                end
                READ: begin
                    r_opA <= rf_r1_data;
                    r_opB <= rf_r2_data;
                end
                EXEC: begin
                    r_alu       <= w_aluNext;
                    r_writeAddr <= r_rd;
                end
                WB: begin
                    r_result    <= r_alu[DATA_W-1:0];
                    r_flagZero  <= (r_alu[DATA_W-1:0] == '0);
                    r_flagCarry <= r_alu[DATA_W];
                end
                default: ;
            endcase
        end
    end

    assign rf_r1_addr    = r_r1Addr;
    assign rf_r2_addr    = r_r2Addr;
    assign rf_write_addr = r_writeAddr;
    assign rf_write_data = r_alu[DATA_W-1:0];
    assign result        = r_result;
    assign flag_zero     = r_flagZero;
    assign flag_carry    = r_flagCarry;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer with a behavioural register file attached to its
// read/write ports; vector table plus hand-written multi-cycle sequences.
module tb_reg_op_sequencer;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_opcode;
    logic [7:0] in_rd;
    logic [7:0] in_rs1;
    logic [7:0] in_rs2;
    logic [7:0] rf_r1_addr;
    logic [7:0] rf_r2_addr;
    logic [7:0] rf_r1_data;
    logic [7:0] rf_r2_data;
    logic [7:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       rf_write_ctrl;
    logic       done;
    logic [7:0] result;
    logic       flag_zero;
    logic       flag_carry;

    logic [7:0] regs [0:255];
    logic       tbWe;
    logic [7:0] tbWa;
    logic [7:0] tbWd;
    int         writeCount;
    int         doneCount;

    int checks;
    int passes;
    int lastLatency;
    int lastReadyLow;
    logic [7:0] capWAddr;
    logic [7:0] capWData;
    logic       capWCtrl;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expRes;
        logic       expCarry;
        logic       expZero;
    } vec_t;

    vec_t vecs [10];

    reg_op_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_opcode(in_opcode),
        .in_rd(in_rd),
        .in_rs1(in_rs1),
        .in_rs2(in_rs2),
        .rf_r1_addr(rf_r1_addr),
        .rf_r2_addr(rf_r2_addr),
        .rf_r1_data(rf_r1_data),
        .rf_r2_data(rf_r2_data),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .rf_write_ctrl(rf_write_ctrl),
        .done(done),
        .result(result),
        .flag_zero(flag_zero),
        .flag_carry(flag_carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rf_r1_data = regs[rf_r1_addr];
    assign rf_r2_data = regs[rf_r2_addr];

    // Register file: sequencer writes commit on posedge; bench preloads share the port.
    always @(posedge clock) begin
        if (rf_write_ctrl) begin
            regs[rf_write_addr] <= rf_write_data;
            writeCount <= writeCount + 1;
        end else if (tbWe) begin
            regs[tbWa] <= tbWd;
        end
        if (done) doneCount <= doneCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic setReg(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clock);
        tbWe = 1'b1;
        tbWa = addr;
        tbWd = data;
        @(negedge clock);
        tbWe = 1'b0;
    endtask

    // Present one instruction, accept it, then follow it to its WB cycle.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] rd,
                                 input logic [7:0] rs1, input logic [7:0] rs2,
                                 input bit waitFirst);
        if (waitFirst) @(negedge clock);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        @(posedge clock);
        #1 in_valid = 1'b0;
        lastLatency  = 0;
        lastReadyLow = 0;
        capWCtrl     = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (!in_ready) lastReadyLow++;
            if (done) begin
                lastLatency = i;
                capWCtrl    = rf_write_ctrl;
                capWAddr    = rf_write_addr;
                capWData    = rf_write_data;
                break;
            end
        end
        if (lastLatency == 0) begin
            checks++;
            $display("[TB] FAIL done_timeout: actual=no done required=done within 10 cycles");
        end
    endtask

    initial begin
        int baseWrites;
        int baseDones;
        checks     = 0;
        passes     = 0;
        writeCount = 0;
        doneCount  = 0;
        tbWe       = 1'b0;
        tbWa       = '0;
        tbWd       = '0;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;

        vecs[0] = '{3'b000, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
        vecs[1] = '{3'b001, 8'd5,   8'd5,   8'd0,   1'b0, 1'b1};
        vecs[2] = '{3'b001, 8'd5,   8'd6,   8'hFF,  1'b1, 1'b0};
        vecs[3] = '{3'b101, 8'h81,  8'h00,  8'h02,  1'b1, 1'b0};
        vecs[4] = '{3'b110, 8'h81,  8'h00,  8'h40,  1'b1, 1'b0};
        vecs[5] = '{3'b010, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
        vecs[6] = '{3'b011, 8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0};
        vecs[7] = '{3'b100, 8'hAA,  8'hAA,  8'h00,  1'b0, 1'b1};
        vecs[8] = '{3'b111, 8'h5A,  8'hFF,  8'h5A,  1'b0, 1'b0};
        vecs[9] = '{3'b000, 8'h10,  8'h20,  8'h30,  1'b0, 1'b0};

        // Reset with a valid instruction present: it must not be accepted.
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_opcode = 3'b111;
        in_rd     = 8'd6;
        in_rs1    = 8'd1;
        repeat (2) @(negedge clock);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_write_ctrl", rf_write_ctrl, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_r1_addr", rf_r1_addr, 0);
        checkOutput("reset_r2_addr", rf_r2_addr, 0);
        checkOutput("reset_write_addr", rf_write_addr, 0);
        checkOutput("reset_write_data", rf_write_data, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_flags", {flag_zero, flag_carry}, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checkOutput("post_reset_no_accept", in_ready, 1);

        for (int v = 0; v < 10; v++) begin
            setReg(8'd1, vecs[v].a);
            setReg(8'd2, vecs[v].b);
            setReg(8'd3, 8'hEE);
            applyStimulus(vecs[v].op, 8'd3, 8'd1, 8'd2, 1'b1);
            checkOutput($sformatf("v%0d_latency", v), lastLatency, 3);
            checkOutput($sformatf("v%0d_ready_low", v), lastReadyLow, 3);
            checkOutput($sformatf("v%0d_write_ctrl", v), capWCtrl, 1);
            checkOutput($sformatf("v%0d_write_addr", v), capWAddr, 3);
            checkOutput($sformatf("v%0d_write_data", v), capWData, vecs[v].expRes);
            @(negedge clock);
            checkOutput($sformatf("v%0d_done_cleared", v), {done, rf_write_ctrl}, 0);
            checkOutput($sformatf("v%0d_reg", v), regs[3], vecs[v].expRes);
            checkOutput($sformatf("v%0d_result", v), result, vecs[v].expRes);
            checkOutput($sformatf("v%0d_carry", v), flag_carry, vecs[v].expCarry);
            checkOutput($sformatf("v%0d_zero", v), flag_zero, vecs[v].expZero);
            checkOutput($sformatf("v%0d_hold_write_data", v), rf_write_data, vecs[v].expRes);
        end

        // rd == rs1 == rs2, back to back: second instruction sees the first's write.
        setReg(8'd7, 8'd10);
        applyStimulus(3'b000, 8'd7, 8'd7, 8'd7, 1'b1);
        checkOutput("b2b_first_ready_low", lastReadyLow, 3);
        @(negedge clock);
        checkOutput("b2b_first_reg", regs[7], 20);
        checkOutput("b2b_ready_again", in_ready, 1);
        applyStimulus(3'b000, 8'd7, 8'd7, 8'd7, 1'b0);
        checkOutput("b2b_second_latency", lastLatency, 3);
        @(negedge clock);
        checkOutput("b2b_second_reg", regs[7], 40);
        checkOutput("b2b_second_result", result, 40);

        // New instruction held on in_* while busy must be ignored.
        setReg(8'd1, 8'h11);
        setReg(8'd2, 8'h22);
        setReg(8'd9, 8'h77);
        baseWrites = writeCount;
        @(negedge clock);
        in_valid  = 1'b1;
        in_opcode = 3'b000;
        in_rd     = 8'd3;
        in_rs1    = 8'd1;
        in_rs2    = 8'd2;
        @(posedge clock);
        #1;
        in_opcode = 3'b111;
        in_rd     = 8'd9;
        in_rs1    = 8'd2;
        lastLatency = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (done) begin
                lastLatency = i;
                break;
            end
        end
        in_valid = 1'b0;
        checkOutput("busy_latency", lastLatency, 3);
        @(negedge clock);
        checkOutput("busy_target_reg", regs[3], 8'h33);
        checkOutput("busy_result", result, 8'h33);
        repeat (4) @(negedge clock);
        checkOutput("busy_ignored_reg", regs[9], 8'h77);
        checkOutput("busy_single_write", writeCount - baseWrites, 1);

        // Reset in EXEC drops the instruction without a write.
        setReg(8'd5, 8'hC5);
        baseWrites = writeCount;
        baseDones  = doneCount;
        @(negedge clock);
        in_valid  = 1'b1;
        in_opcode = 3'b000;
        in_rd     = 8'd5;
        in_rs1    = 8'd1;
        in_rs2    = 8'd2;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("exec_busy", in_ready, 0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_exec_write_ctrl", rf_write_ctrl, 0);
        checkOutput("rst_exec_done", done, 0);
        checkOutput("rst_exec_result", result, 0);
        checkOutput("rst_exec_flags", {flag_zero, flag_carry}, 0);
        checkOutput("rst_exec_addrs", {rf_r1_addr, rf_r2_addr, rf_write_addr}, 0);
        checkOutput("rst_exec_write_data", rf_write_data, 0);
        reset = 1'b0;
        checkOutput("rst_exec_ready", in_ready, 1);
        repeat (4) @(negedge clock);
        checkOutput("rst_exec_no_write", writeCount - baseWrites, 0);
        checkOutput("rst_exec_no_done", doneCount - baseDones, 0);
        checkOutput("rst_exec_reg_kept", regs[5], 8'hC5);
        checkOutput("rst_exec_idle", in_ready, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
